// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads four little-endian bytes per word from the toggle-triggered
// byte rom and presents the assembled word with its PC over a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] rom_addr,
  output logic        rom_trigger,
  input  logic [7:0]  rom_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_en,
  input  logic [31:0] branch_target
);

  typedef enum logic [2:0] {IDLE, ADDR, TRIG, WAIT, HOLD} state_t;

  localparam int unsigned     WW        = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;
  localparam logic [WW-1:0]   WAIT_LOAD = WW'(ROM_WAIT - 1);

  state_t        state;
  logic [31:0]   pc;
  logic [1:0]    byte_idx;
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC & ~32'h3;
      byte_idx    <= '0;
      wait_cnt    <= '0;
      rom_addr    <= '0;
      rom_trigger <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (branch_en) begin
      // Redirect wins over everything; a toggle already issued is left alone and its byte ignored.
      pc          <= branch_target & ~32'h3;
      byte_idx    <= '0;
      instr_valid <= 1'b0;
      state       <= ADDR;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            byte_idx <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          rom_addr <= pc + {30'b0, byte_idx};
          state    <= TRIG;
        end
        TRIG: begin
          rom_trigger <= ~rom_trigger;
          wait_cnt    <= WAIT_LOAD;
          state       <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            instr[{byte_idx, 3'b000} +: 8] <= rom_data;
            if (byte_idx == 2'd3) begin
              instr_valid <= 1'b1;
              instr_pc    <= pc;
              state       <= HOLD;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= ADDR;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= pc + 32'd4;
            byte_idx    <= '0;
            state       <= fetch_en ? ADDR : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: byte rom model, directed sequences, a vector table and a
// randomized run against a word-level model of the fetch stream.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] rom_addr;
  logic        rom_trigger;
  logic [7:0]  rom_data = '0;
  logic [31:0] instr, instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_target = '0;

  logic [31:0] w_rom_addr, w_instr, w_instr_pc;
  logic        w_rom_trigger, w_instr_valid;
  logic [7:0]  w_rom_data = '0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .ROM_WAIT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_addr(rom_addr),
    .rom_trigger(rom_trigger), .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch_en(branch_en),
    .branch_target(branch_target)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .ROM_WAIT(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(1'b1), .rom_addr(w_rom_addr),
    .rom_trigger(w_rom_trigger), .rom_data(w_rom_data), .instr(w_instr), .instr_pc(w_instr_pc),
    .instr_valid(w_instr_valid), .instr_ready(1'b1), .branch_en(1'b0),
    .branch_target(32'h0)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {rom_byte(a + 32'd3), rom_byte(a + 32'd2), rom_byte(a + 32'd1), rom_byte(a)};
  endfunction

  // Rom model: each trigger toggle fetches the byte at the current address half a cycle later.
  logic        last_trig = 1'b0, w_last = 1'b0;
  logic [31:0] tq[$], w_tq[$], w_pcq[$], w_iq[$];

  always @(negedge clk) begin
    if (!rst_n) last_trig <= 1'b0;
    else if (rom_trigger !== last_trig) begin
      last_trig <= rom_trigger;
      rom_data  <= rom_byte(rom_addr);
      tq.push_back(rom_addr);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) w_last <= 1'b0;
    else begin
      if (w_rom_trigger !== w_last) begin
        w_last     <= w_rom_trigger;
        w_rom_data <= rom_byte(w_rom_addr);
        w_tq.push_back(w_rom_addr);
      end
      if (w_instr_valid) begin
        w_pcq.push_back(w_instr_pc);
        w_iq.push_back(w_instr);
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_valid_timeout"}, {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic wait_toggles(input int unsigned k);
    int n = 0;
    while (tq.size() < k && n < 200) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] tq_at(input int unsigned i);
    return (i < tq.size()) ? tq[i] : 32'hDEAD_DEAD;
  endfunction

  typedef struct {
    logic [31:0] target;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [31:0] s_instr, s_pc, s_addr;
    logic        s_trig;
    logic [31:0] exp_pc;
    logic        prev;
    int          n;
    int          delivered;

    vt[0] = '{32'h0000_0103, 8'h11, 8'h22, 8'h33, 8'h44, 32'h0000_0100, 32'h4433_2211};
    vt[1] = '{32'h0000_0200, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'h0000_0200, 32'hDEAD_BEEF};
    vt[2] = '{32'h0000_0FFE, 8'h01, 8'h00, 8'hA0, 8'hE3, 32'h0000_0FFC, 32'hE3A0_0001};
    vt[3] = '{32'h8000_0001, 8'h0F, 8'hF0, 8'h5A, 8'hA5, 32'h8000_0000, 32'hA55A_F00F};
    mem[32'h0] = 8'h78; mem[32'h1] = 8'h56; mem[32'h2] = 8'h34; mem[32'h3] = 8'h12;
    for (int i = 0; i < 4; i++) begin
      mem[vt[i].exp_pc]          = vt[i].b0;
      mem[vt[i].exp_pc + 32'd1]  = vt[i].b1;
      mem[vt[i].exp_pc + 32'd2]  = vt[i].b2;
      mem[vt[i].exp_pc + 32'd3]  = vt[i].b3;
    end

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_addr", rom_addr, 32'h0);
    chk("rst_trigger", {31'b0, rom_trigger}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_no_toggle", tq.size(), 32'd0);

    // T1 basic fetch and latency
    fetch_en = 1'b1;
    tq.delete();
    tick();
    n = 0;
    while (!instr_valid && n < 64) begin
      tick();
      n++;
    end
    chk("t1_latency", n, 32'd16);
    chk("t1_instr", instr, 32'h1234_5678);
    chk("t1_instr_pc", instr_pc, 32'h0);
    chk("t1_toggles", tq.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_rom_addr", tq_at(i), 32'(i));

    // T2 backpressure
    s_instr = instr; s_pc = instr_pc; s_addr = rom_addr; s_trig = rom_trigger;
    repeat (5) begin
      tick();
      chk("t2_instr", instr, s_instr);
      chk("t2_pc", instr_pc, s_pc);
      chk("t2_addr", rom_addr, s_addr);
      chk("t2_trig", {31'b0, rom_trigger}, {31'b0, s_trig});
      chk("t2_valid", {31'b0, instr_valid}, 32'd1);
    end
    instr_ready = 1'b1;
    tq.delete();
    tick();
    instr_ready = 1'b0;
    chk("t2_valid_drop", {31'b0, instr_valid}, 32'd0);
    wait_toggles(1);
    chk("t2_next_addr", tq_at(0), 32'h4);

    // Vector table: redirect then fetch
    for (int i = 0; i < 4; i++) begin
      instr_ready   = 1'b0;
      branch_en     = 1'b1;
      branch_target = vt[i].target;
      tick();
      branch_en = 1'b0;
      tq.delete();
      chk("tbl_valid_low", {31'b0, instr_valid}, 32'd0);
      wait_valid("tbl");
      chk("tbl_instr_pc", instr_pc, vt[i].exp_pc);
      chk("tbl_instr", instr, vt[i].exp_instr);
      chk("tbl_first_addr", tq_at(0), vt[i].exp_pc);
      chk("tbl_toggles", tq.size(), 32'd4);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      tq.delete();
    end

    // T3 branch while byte 2 is in flight
    wait_toggles(3);
    branch_en = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    branch_en = 1'b0;
    tq.delete();
    chk("t3_valid_low", {31'b0, instr_valid}, 32'd0);
    wait_valid("t3");
    chk("t3_instr_pc", instr_pc, 32'h100);
    chk("t3_instr", instr, 32'h4433_2211);
    chk("t3_first_addr", tq_at(0), 32'h100);
    chk("t3_toggles", tq.size(), 32'd4);

    // Branch coinciding with a handshake: redirect wins, no pc+4
    instr_ready = 1'b1;
    branch_en = 1'b1;
    branch_target = 32'h0000_0200;
    tick();
    branch_en = 1'b0;
    instr_ready = 1'b0;
    tq.delete();
    chk("hs_br_valid", {31'b0, instr_valid}, 32'd0);
    wait_valid("hs_br");
    chk("hs_br_addr", tq_at(0), 32'h200);
    chk("hs_br_instr", instr, 32'hDEAD_BEEF);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tq.delete();

    // T6 fetch_en dropped mid-word
    wait_toggles(2);
    fetch_en = 1'b0;
    wait_valid("t6");
    chk("t6_instr_pc", instr_pc, 32'h204);
    chk("t6_instr", instr, word_at(32'h204));
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tq.delete();
    repeat (20) tick();
    chk("t6_idle_toggles", tq.size(), 32'd0);
    chk("t6_idle_valid", {31'b0, instr_valid}, 32'd0);

    // T5 asynchronous reset in the middle of a byte wait
    fetch_en = 1'b1;
    tq.delete();
    wait_toggles(1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rom_addr", rom_addr, 32'h0);
    chk("t5_trigger", {31'b0, rom_trigger}, 32'h0);
    chk("t5_instr", instr, 32'h0);
    chk("t5_instr_pc", instr_pc, 32'h0);
    chk("t5_valid", {31'b0, instr_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tq.delete();
    wait_valid("t5");
    chk("t5_re_instr", instr, 32'h1234_5678);
    chk("t5_re_pc", instr_pc, 32'h0);
    chk("t5_re_addr", tq_at(0), 32'h0);

    // Randomized run against the word-stream model
    instr_ready   = 1'b0;
    branch_en     = 1'b1;
    branch_target = 32'h0000_0040;
    exp_pc        = 32'h0000_0040;
    tick();
    branch_en = 1'b0;
    prev = rom_trigger;
    delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      fetch_en    = ($urandom_range(0, 9) != 0);
      instr_ready = ($urandom_range(0, 1) == 1);
      branch_en   = ($urandom_range(0, 99) < 3);
      branch_target = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom_range(0, 1023));
      @(negedge clk);
      if (rom_trigger !== prev) begin
        prev = rom_trigger;
        chk("rnd_addr_range", {31'b0, ((rom_addr - exp_pc) < 32'd4)}, 32'd1);
      end
      if (instr_valid && instr_ready) begin
        chk("rnd_instr_pc", instr_pc, exp_pc);
        chk("rnd_instr", instr, word_at(exp_pc));
        delivered++;
        if (!branch_en) exp_pc = exp_pc + 32'd4;
      end
      if (branch_en) exp_pc = branch_target & ~32'h3;
      tick();
    end
    branch_en = 1'b0;
    chk("rnd_progress", {31'b0, (delivered > 10)}, 32'd1);

    // T4 wrap instance (RESET_PC at the top of the address space)
    for (int i = 0; i < 8; i++)
      chk("t4_rom_addr", (i < w_tq.size()) ? w_tq[i] : 32'hDEAD_DEAD, 32'hFFFF_FFFC + 32'(i));
    chk("t4_pc0", (w_pcq.size() > 0) ? w_pcq[0] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
    chk("t4_pc1", (w_pcq.size() > 1) ? w_pcq[1] : 32'hDEAD_DEAD, 32'h0);
    chk("t4_instr0", (w_iq.size() > 0) ? w_iq[0] : 32'hDEAD_DEAD, word_at(32'hFFFF_FFFC));
    chk("t4_instr1", (w_iq.size() > 1) ? w_iq[1] : 32'hDEAD_DEAD, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
